nor_buffer_prog: RTL
====================

# nor_buffer_prog

Parametrised NOR flash buffered-program controller for the Nexys3 parallel NOR (StrataFlash-style command set). Given a base address and a word count of 1..MAX_WORDS, it runs the full sequence: buffer-program setup, SR7 poll, count write, data writes, confirm, program-complete poll, error check/clear, return to read-array. It adds a start/done handshake, a per-word data source, poll timeouts and error reporting. It sits between test/loader logic and the flash pins, replacing fixed-length hard-coded program sequences.

## Interface
- ADDR_W, 24, flash address width (byte address; words at even addresses)
- DATA_W, 16, flash data width
- MAX_WORDS, 32, largest accepted buffer length
- CNT_W, 6, WORD_COUNT width (holds MAX_WORDS)
- WE_CYCLES, 2, cycles CE_N/WE_N held low per bus write
- RD_CYCLES, 4, cycles CE_N/OE_N held low per bus read; DATA sampled on last
- TIMEOUT, 100000, max cycles spent in one poll phase
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle request; sampled only in IDLE
- BASE_ADDR  in  ADDR_W  buffer start address, captured on START
- WORD_COUNT  in  CNT_W  words to program, captured on START
- WR_REQ  out  1  one-cycle pulse: WR_DATA for word WR_IDX is captured this cycle
- WR_IDX  out  CNT_W  index of requested word, 0..N-1
- WR_DATA  in  DATA_W  word to program, valid combinationally while WR_REQ high
- CE_N, WE_N, OE_N  out  1 each  flash strobes, active low
- ADDR  out  ADDR_W  flash address
- DATA  inout  DATA_W  flash data; driven only during write strobes, else high-Z
- BUSY  out  1  sequence in progress
- DONE  out  1  one-cycle pulse at sequence end (success or error)
- ERR_CODE  out  3  0 ok, 1 bad count, 2 setup timeout, 3 program timeout, 4 device error; held until next START
- STATUS  out  8  last status register value read

## Operation
- Bus write: CE_N=WE_N=0, DATA driven for WE_CYCLES cycles, then one recovery cycle with all strobes high and DATA released.
- Bus read: CE_N=OE_N=0 for RD_CYCLES cycles, DATA[7:0] sampled into STATUS on last, then one recovery cycle.
- States: IDLE, SETUP_WR (0x00E8 @BASE), SETUP_POLL (read @BASE until STATUS[7]=1), CNT_WR (N-1 @BASE), DATA_WR (word i @BASE+2i, i=0..N-1), CONF_WR (0x00D0 @BASE), PROG_POLL (read until STATUS[7]=1), CLR_WR (0x0050 @BASE, device error only), ARRAY_WR (0x00FF @BASE), FINISH.
- WORD_COUNT=0 or >MAX_WORDS: no bus activity, ERR_CODE=1, DONE next cycle.
- Timeout counter clears on poll-phase entry, increments every cycle in phase; reaching TIMEOUT with SR7=0 sets ERR_CODE 2/3 and goes to ARRAY_WR.
- After PROG_POLL success, any of STATUS[5,4,3,1] set: ERR_CODE=4, CLR_WR then ARRAY_WR; otherwise ARRAY_WR directly.
- Address arithmetic BASE+2i in ADDR_W bits, wraps modulo 2^ADDR_W; no block-boundary check.
- START while BUSY ignored. WR_REQ pulses on the first strobe cycle of each DATA_WR write, WR_IDX=i.

## Timing
- Reset values: CE_N=WE_N=OE_N=1, DATA high-Z, ADDR=0, BUSY=0, DONE=0, WR_REQ=0, WR_IDX=0, ERR_CODE=0, STATUS=0, state IDLE.
- START at edge t: BUSY=1 and first strobe low from t+1.
- Success with SR7 already 1 on first read of each poll: DONE at t+1+(N+4)(WE_CYCLES+1)+2(RD_CYCLES+1); defaults, N=4: t+35. BUSY drops with DONE.
- Each extra poll read adds RD_CYCLES+1 cycles.
- RESET mid-sequence: all outputs to reset values at next edge, DATA released same edge; flash may remain in buffer mode, caller reissues sequence.

## Test plan
- Flash model SR7=1 immediately, BASE=0x3F0000, N=4, data 0x52..0x55 -> writes E8,0003,0052@3F0000,0053@3F0002,0054@3F0004,0055@3F0006,D0,FF; DONE at t+35, ERR_CODE=0.
- N=1 and N=32 -> count words 0x0000 and 0x001F, 1 and 32 WR_REQ pulses, ADDR last 0x3F003E for N=32.
- WORD_COUNT=0 and 33 -> no strobe activity, DONE at t+1, ERR_CODE=1.
- SR7 held 0 in PROG_POLL, TIMEOUT=50 -> ERR_CODE=3, 0xFF write issued, DONE pulse; setup-phase variant -> ERR_CODE=2.
- Model returns SR=0x90 after program -> ERR_CODE=4, STATUS=0x90, 0x50 then 0xFF written.
- RESET asserted during DATA_WR word 2 -> next edge strobes high, DATA high-Z, BUSY=0; new START runs full sequence; START during BUSY ignored.

Source files
------------

// File: rtl/nor_buffer_prog.sv
`default_nettype none
// ============================================================================
//  Module      : nor_buffer_prog
//  Description : Buffered-program controller for a StrataFlash-style parallel
//                NOR. It runs setup, status poll, count, data, confirm,
//                program poll, error clear and read-array, with a start/done
//                handshake, per-word data requests and poll timeouts.
//  Revision    : 1.0 - initial release
// ============================================================================
module nor_buffer_prog #(
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16,
  parameter int MAX_WORDS = 32,
  parameter int CNT_W     = 6,
  parameter int WE_CYCLES = 2,
  parameter int RD_CYCLES = 4,
  parameter int TIMEOUT   = 100000
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              START,
  input  logic [ADDR_W-1:0] BASE_ADDR,
  input  logic [CNT_W-1:0]  WORD_COUNT,
  output logic              WR_REQ,
  output logic [CNT_W-1:0]  WR_IDX,
  input  logic [DATA_W-1:0] WR_DATA,
  output logic              CE_N,
  output logic              WE_N,
  output logic              OE_N,
  output logic [ADDR_W-1:0] ADDR,
  inout  wire  [DATA_W-1:0] DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic [2:0]        ERR_CODE,
  output logic [7:0]        STATUS
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    SETUP_WR   = 4'd1,
    SETUP_POLL = 4'd2,
    CNT_WR     = 4'd3,
    DATA_WR    = 4'd4,
    CONF_WR    = 4'd5,
    PROG_POLL  = 4'd6,
    CLR_WR     = 4'd7,
    ARRAY_WR   = 4'd8,
    FINISH     = 4'd9
  } state_t;

  localparam logic [7:0]  WE_LAST  = 8'(WE_CYCLES - 1);
  localparam logic [7:0]  WE_END   = 8'(WE_CYCLES);
  localparam logic [7:0]  RD_LAST  = 8'(RD_CYCLES - 1);
  localparam logic [7:0]  RD_END   = 8'(RD_CYCLES);
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [7:0]          cyc_q, cyc_d;
  logic [31:0]         tmo_q, tmo_d;
  logic [CNT_W-1:0]    idx_q, idx_d, n_q, n_d, wr_idx_q, wr_idx_d;
  logic [ADDR_W-1:0]   base_q, base_d, addr_q, addr_d;
  logic                ce_q, ce_d, we_q, we_d, oe_q, oe_d, drv_q, drv_d;
  logic                busy_q, busy_d, done_q, done_d, wr_req_q, wr_req_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [2:0]          err_q, err_d;
  logic [7:0]          status_q, status_d;

  logic                w_go_wr, w_go_rd, w_wr_st, w_rd_st, w_wr_end, w_rd_end, w_tmo;
  logic [ADDR_W-1:0]   w_go_addr, w_nx_addr;
  logic [DATA_W-1:0]   w_go_data;
  logic [CNT_W-1:0]    w_idx_nx;

  assign w_wr_st   = (state_q == SETUP_WR) || (state_q == CNT_WR) || (state_q == DATA_WR) ||
                     (state_q == CONF_WR)  || (state_q == CLR_WR) || (state_q == ARRAY_WR);
  assign w_rd_st   = (state_q == SETUP_POLL) || (state_q == PROG_POLL);
  assign w_wr_end  = w_wr_st && (cyc_q == WE_END);
  assign w_rd_end  = w_rd_st && (cyc_q == RD_END);
  assign w_tmo     = (tmo_q >= TMO_LAST);
  assign w_idx_nx  = idx_q + CNT_W'(1);
  // Word i lives at BASE + 2i; the sum wraps naturally in ADDR_W bits.
  assign w_nx_addr = base_q + {{(ADDR_W-CNT_W-1){1'b0}}, w_idx_nx, 1'b0};

  // Next-state logic: sequence the bus cycles and pick the next flash operation.
  always_comb begin
    state_d   = state_q;   cyc_d    = cyc_q;    tmo_d    = tmo_q;
    idx_d     = idx_q;     n_d      = n_q;      base_d   = base_q;
    ce_d      = ce_q;      we_d     = we_q;     oe_d     = oe_q;
    drv_d     = drv_q;     dout_d   = dout_q;   addr_d   = addr_q;
    busy_d    = busy_q;    done_d   = 1'b0;     wr_req_d = 1'b0;
    wr_idx_d  = wr_idx_q;  err_d    = err_q;    status_d = status_q;
    w_go_wr   = 1'b0;      w_go_rd  = 1'b0;
    w_go_addr = base_q;    w_go_data = '0;

    // Write strobe: WE_CYCLES low, then one recovery cycle with DATA released.
    if (w_wr_st) begin
      cyc_d = cyc_q + 8'd1;
      if (wr_req_q) dout_d = WR_DATA;
      if (cyc_q == WE_LAST) begin
        ce_d  = 1'b1;
        we_d  = 1'b1;
        drv_d = 1'b0;
      end
    end
    // Read strobe: status sampled on the last low cycle, then recovery.
    if (w_rd_st) begin
      cyc_d = cyc_q + 8'd1;
      tmo_d = tmo_q + 32'd1;
      if (cyc_q == RD_LAST) begin
        status_d = DATA[7:0];
        ce_d     = 1'b1;
        oe_d     = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (START) begin
          if ((WORD_COUNT == '0) || (WORD_COUNT > CNT_W'(MAX_WORDS))) begin
            err_d   = 3'd1;
            done_d  = 1'b1;
            state_d = FINISH;
          end else begin
            err_d     = 3'd0;
            base_d    = BASE_ADDR;
            n_d       = WORD_COUNT;
            busy_d    = 1'b1;
            state_d   = SETUP_WR;
            w_go_wr   = 1'b1;
            w_go_addr = BASE_ADDR;
            w_go_data = DATA_W'(16'h00E8);
          end
        end
      end
      SETUP_WR: begin
        if (w_wr_end) begin
          state_d = SETUP_POLL;
          tmo_d   = '0;
          w_go_rd = 1'b1;
        end
      end
      SETUP_POLL: begin
        if (w_rd_end) begin
          if (status_q[7]) begin
            state_d   = CNT_WR;
            w_go_wr   = 1'b1;
            w_go_data = {{(DATA_W-CNT_W){1'b0}}, n_q - CNT_W'(1)};
          end else if (w_tmo) begin
            err_d     = 3'd2;
            state_d   = ARRAY_WR;
            w_go_wr   = 1'b1;
            w_go_data = DATA_W'(16'h00FF);
          end else begin
            w_go_rd = 1'b1;
          end
        end
      end
      CNT_WR: begin
        if (w_wr_end) begin
          state_d  = DATA_WR;
          idx_d    = '0;
          wr_req_d = 1'b1;
          wr_idx_d = '0;
          w_go_wr  = 1'b1;
        end
      end
      DATA_WR: begin
        if (w_wr_end) begin
          if (idx_q == n_q - CNT_W'(1)) begin
            state_d   = CONF_WR;
            w_go_wr   = 1'b1;
            w_go_data = DATA_W'(16'h00D0);
          end else begin
            idx_d     = w_idx_nx;
            wr_req_d  = 1'b1;
            wr_idx_d  = w_idx_nx;
            w_go_wr   = 1'b1;
            w_go_addr = w_nx_addr;
          end
        end
      end
      CONF_WR: begin
        if (w_wr_end) begin
          state_d = PROG_POLL;
          tmo_d   = '0;
          w_go_rd = 1'b1;
        end
      end
      PROG_POLL: begin
        if (w_rd_end) begin
          if (status_q[7]) begin
            w_go_wr = 1'b1;
            if (status_q[5] || status_q[4] || status_q[3] || status_q[1]) begin
              err_d     = 3'd4;
              state_d   = CLR_WR;
              w_go_data = DATA_W'(16'h0050);
            end else begin
              state_d   = ARRAY_WR;
              w_go_data = DATA_W'(16'h00FF);
            end
          end else if (w_tmo) begin
            err_d     = 3'd3;
            state_d   = ARRAY_WR;
            w_go_wr   = 1'b1;
            w_go_data = DATA_W'(16'h00FF);
          end else begin
            w_go_rd = 1'b1;
          end
        end
      end
      CLR_WR: begin
        if (w_wr_end) begin
          state_d   = ARRAY_WR;
          w_go_wr   = 1'b1;
          w_go_data = DATA_W'(16'h00FF);
        end
      end
      ARRAY_WR: begin
        if (w_wr_end) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Launch the chosen bus cycle on the same edge the previous one ends.
    if (w_go_wr) begin
      ce_d = 1'b0; we_d = 1'b0; oe_d = 1'b1; drv_d = 1'b1;
      dout_d = w_go_data; addr_d = w_go_addr; cyc_d = '0;
    end
    if (w_go_rd) begin
      ce_d = 1'b0; oe_d = 1'b0; we_d = 1'b1; drv_d = 1'b0;
      addr_d = w_go_addr; cyc_d = '0;
    end
  end

  // State and registered outputs; synchronous reset returns the bus to idle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;  cyc_q  <= '0;   tmo_q    <= '0;   idx_q    <= '0;
      n_q     <= '0;    base_q <= '0;   ce_q     <= 1'b1; we_q     <= 1'b1;
      oe_q    <= 1'b1;  drv_q  <= 1'b0; dout_q   <= '0;   addr_q   <= '0;
      busy_q  <= 1'b0;  done_q <= 1'b0; wr_req_q <= 1'b0; wr_idx_q <= '0;
      err_q   <= '0;    status_q <= '0;
    end else begin
      state_q <= state_d; cyc_q  <= cyc_d;  tmo_q    <= tmo_d;    idx_q    <= idx_d;
      n_q     <= n_d;     base_q <= base_d; ce_q     <= ce_d;     we_q     <= we_d;
      oe_q    <= oe_d;    drv_q  <= drv_d;  dout_q   <= dout_d;   addr_q   <= addr_d;
      busy_q  <= busy_d;  done_q <= done_d; wr_req_q <= wr_req_d; wr_idx_q <= wr_idx_d;
      err_q   <= err_d;   status_q <= status_d;
    end
  end

  // The first strobe cycle of a data write forwards WR_DATA straight through.
  assign DATA     = drv_q ? (wr_req_q ? WR_DATA : dout_q) : {DATA_W{1'bz}};
  assign CE_N     = ce_q;
  assign WE_N     = we_q;
  assign OE_N     = oe_q;
  assign ADDR     = addr_q;
  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign WR_REQ   = wr_req_q;
  assign WR_IDX   = wr_idx_q;
  assign ERR_CODE = err_q;
  assign STATUS   = status_q;

endmodule
`default_nettype wire
